// File: rtl/spi_pkg.sv
// Purpose : shared state encoding and default constants for the SPI burst controller.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package spi_pkg;

  localparam int FIFO_DEPTH_DEF    = 16;
  localparam int CS_SETUP_CLKS_DEF = 2;
  localparam int CS_HOLD_CLKS_DEF  = 4;

  // Byte clocked out when a transfer is due but nothing is queued.
  localparam logic [7:0] UNDERFLOW_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SEND,
    ST_WAIT_RX,
    ST_CS_HOLD,
    ST_CS_GAP
  } state_t;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Purpose : host-side and SPI-master-side signals of spi_burst_ctrl in one bundle.
// Latency : n/a (wiring only).
// Backpressure : i_TX_Ready from the SPI master stalls byte issue.
// Ports   : write port (i_Wr_En/i_Wr_Byte/o_Full/o_Overflow), burst control
//           (i_Start/i_Len/o_Busy/o_Done/o_Underflow), SPI master TX/RX, chip select.
// master  : the side driving the controller (host + SPI master); slave: the controller.
interface spi_burst_ctrl_if;

  logic       i_Wr_En;
  logic [7:0] i_Wr_Byte;
  logic       o_Full;
  logic       o_Overflow;
  logic       i_Start;
  logic [7:0] i_Len;
  logic       o_Busy;
  logic       o_Done;
  logic       o_Underflow;
  logic [7:0] o_TX_Byte;
  logic       o_TX_DV;
  logic       i_TX_Ready;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_SPI_CS_n;

  modport master (
    output i_Wr_En, i_Wr_Byte, i_Start, i_Len, i_TX_Ready, i_RX_DV, i_RX_Byte,
    input  o_Full, o_Overflow, o_Busy, o_Done, o_Underflow, o_TX_Byte, o_TX_DV,
           o_RX_DV, o_RX_Byte, o_SPI_CS_n
  );

  modport slave (
    input  i_Wr_En, i_Wr_Byte, i_Start, i_Len, i_TX_Ready, i_RX_DV, i_RX_Byte,
    output o_Full, o_Overflow, o_Busy, o_Done, o_Underflow, o_TX_Byte, o_TX_DV,
           o_RX_DV, o_RX_Byte, o_SPI_CS_n
  );

endinterface

// File: rtl/spi_byte_fifo.sv
// Purpose : synchronous byte FIFO with occupancy count; head is visible combinationally.
// Latency : push visible at head one cycle after the write edge.
// Backpressure : push ignored when full unless a pop happens the same cycle; pop ignored when empty.
// Ports   : i_Push/i_Push_Dat write side, i_Pop/o_Head read side, o_Full/o_Empty/o_Count status.
module spi_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_Push,
  input  logic [W-1:0]             i_Push_Dat,
  input  logic                     i_Pop,
  output logic [W-1:0]             o_Head,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_Full   = (r_count == FULL_CNT);
  assign o_Empty  = (r_count == '0);
  assign o_Count  = r_count;
  assign o_Head   = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push then.
  assign w_pop_ok  = i_Pop && !o_Empty;
  assign w_push_ok = i_Push && (!o_Full || w_pop_ok);

  always_ff @(posedge i_Clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_Push_Dat;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Purpose : drives chip select and feeds queued bytes to an SPI master one per received byte.
// Latency : first TX byte CS_SETUP_CLKS+1 cycles after CS falls; RX forwarded with 1-cycle delay.
// Backpressure : byte issue waits for i_TX_Ready; host writes to a full FIFO are dropped (o_Overflow).
// Ports   : i_Clk, i_Rst_L (async, active-low), bus (spi_burst_ctrl_if.slave).
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int CS_SETUP_CLKS = CS_SETUP_CLKS_DEF,
  parameter int CS_HOLD_CLKS  = CS_HOLD_CLKS_DEF
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  spi_burst_ctrl_if.slave  bus
);

  localparam int             CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]     SETUP_LAST = 8'(CS_SETUP_CLKS - 1);
  localparam logic [7:0]     HOLD_LAST  = 8'(CS_HOLD_CLKS - 1);

  state_t           r_state;
  logic [7:0]       r_len_cnt;
  logic [7:0]       r_tmr;
  logic             r_cs_n;
  logic [7:0]       r_tx_byte;
  logic             r_tx_dv;
  logic             r_underflow;
  logic             r_done;
  logic             r_overflow;
  logic             r_rx_dv;
  logic [7:0]       r_rx_byte;

  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_send_fire;

  spi_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Push     (bus.i_Wr_En),
    .i_Push_Dat (bus.i_Wr_Byte),
    .i_Pop      (w_pop),
    .o_Head     (w_head),
    .o_Full     (w_full),
    .o_Empty    (w_empty),
    .o_Count    (w_count)
  );

  assign w_send_fire = (r_state == ST_SEND) && bus.i_TX_Ready;
  assign w_pop       = w_send_fire && !w_empty;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= ST_IDLE;
      r_len_cnt   <= '0;
      r_tmr       <= '0;
      r_cs_n      <= 1'b1;
      r_tx_byte   <= 8'h00;
      r_tx_dv     <= 1'b0;
      r_underflow <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_tx_dv     <= 1'b0;
      r_underflow <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_Start && (bus.i_Len != 8'd0)) begin
            r_len_cnt <= bus.i_Len;
            r_tmr     <= '0;
            r_cs_n    <= 1'b0;
            r_state   <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (r_tmr == SETUP_LAST) begin
            r_tmr   <= '0;
            r_state <= ST_SEND;
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        ST_SEND: begin
          if (w_send_fire) begin
            r_tx_dv     <= 1'b1;
            r_tx_byte   <= w_empty ? UNDERFLOW_BYTE : w_head;
            r_underflow <= w_empty;
            r_len_cnt   <= r_len_cnt - 8'd1;
            r_state     <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          // Exactly one byte issued per received byte: only i_RX_DV releases this state.
          if (bus.i_RX_DV) begin
            if (r_len_cnt != 8'd0) begin
              r_state <= ST_SEND;
            end else begin
              r_tmr   <= '0;
              r_state <= ST_CS_HOLD;
            end
          end
        end
        ST_CS_HOLD: begin
          if (r_tmr == HOLD_LAST) begin
            r_tmr   <= '0;
            r_cs_n  <= 1'b1;
            r_state <= ST_CS_GAP;
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        ST_CS_GAP: begin
          if (r_tmr == HOLD_LAST) begin
            r_tmr   <= '0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        default: begin
          r_cs_n  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // RX bytes only count while the slave is selected; stray pulses with CS high are dropped.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx_dv    <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_rx_dv <= bus.i_RX_DV && !r_cs_n;
      if (bus.i_RX_DV && !r_cs_n) r_rx_byte <= bus.i_RX_Byte;
      r_overflow <= bus.i_Wr_En && (w_count == FULL_CNT) && !w_pop;
    end
  end

  assign bus.o_Full      = w_full;
  assign bus.o_Overflow  = r_overflow;
  assign bus.o_Busy      = (r_state != ST_IDLE);
  assign bus.o_Done      = r_done;
  assign bus.o_Underflow = r_underflow;
  assign bus.o_TX_Byte   = r_tx_byte;
  assign bus.o_TX_DV     = r_tx_dv;
  assign bus.o_RX_DV     = r_rx_dv;
  assign bus.o_RX_Byte   = r_rx_byte;
  assign bus.o_SPI_CS_n  = r_cs_n;

endmodule
